hazard_ctrl: RTL
================

Name: hazard_ctrl

Overview:
Pipeline hazard controller for the 5-stage core.
- Tracks in-flight register writes in a 3-slot scoreboard (EX, MEM, WB).
- Detects read-after-write hazards for the instruction in ID and generates stall and bubble controls.
- Sequences flushes for JAL/JALR resolved in ID and branches resolved in MEM.
- Sits beside id_stage and drives the IF PC hold, the IF/ID register and the ID/EX control registers.

Parameters:
ADDR_WIDTH, 5, register address width (from riscv_cpu_pkg)
CNT_WIDTH, 32, width of stall performance counter

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset; asynchronous, active-low
id_valid_i  in  1  ID holds a valid instruction
id_rs1_addr_i  in  ADDR_WIDTH  rs1 of ID instruction
id_rs1_used_i  in  1  instruction reads rs1
id_rs2_addr_i  in  ADDR_WIDTH  rs2 of ID instruction
id_rs2_used_i  in  1  instruction reads rs2
id_rd_addr_i  in  ADDR_WIDTH  rd of ID instruction
id_reg_we_i  in  1  ID instruction writes rd
id_is_load_i  in  1  ID instruction is a load
jump_i  in  1  JAL/JALR decoded in ID (jal_op)
branch_taken_i  in  1  branch resolved taken in MEM
stall_o  out  1  hold PC and IF/ID register
bubble_o  out  1  zero ex/mem/wb control into ID/EX
flush_if_o  out  1  kill IF/ID contents next edge
flush_ex_o  out  1  kill ID/EX and EX/MEM controls
fwd_a_sel_o  out  2  operand A forward select for EX (FORWARDING_EN only)
fwd_b_sel_o  out  2  operand B forward select for EX (FORWARDING_EN only)
stall_cnt_o  out  CNT_WIDTH  saturating count of stall cycles

Behaviour:
- Scoreboard: slots EX, MEM, WB, each {valid, rd, is_load}.
  - Every edge: WB<=MEM, MEM<=EX.
  - EX<=ID info when id_valid_i & id_reg_we_i & rd!=0 & !stall_o & !branch_taken_i; otherwise EX<=invalid.
- Register file is not write-through; a WB-slot producer is therefore a hazard.
- Match(s): slot.valid & rs_used & rs!=0 & rs==slot.rd. x0 never hazards.
- Hazard, without FORWARDING_EN: any match against EX, MEM or WB for rs1 or rs2, with id_valid_i=1.
- stall_o=bubble_o=hazard & !branch_taken_i. Combinational, same cycle.
- Stall lasts until the producer leaves WB: max 3 cycles; 2 if the producer is in MEM; 1 if in WB.
- jump_i: flush_if_o=jump_i & id_valid_i & !stall_o. A stalled jump is not honored; ID re-presents it.
- branch_taken_i (highest priority):
  - flush_if_o=1, flush_ex_o=1, stall_o=0, bubble_o=1.
  - Scoreboard EX slot is invalidated at the edge; MEM<=invalid because the EX-stage instruction is killed.
  - WB<=MEM is unaffected (an older instruction still retires).
- Simultaneous jump_i and branch_taken_i: the branch wins; the jump is discarded with the flushed ID.
- stall_cnt_o increments on each cycle with stall_o=1 and saturates at all-ones.
- Reset (async): all slots invalid; stall_cnt_o=0; fwd sels=0. Outputs are then combinational zero with inputs idle.
- Reset mid-stall: stall drops immediately; no residual hazard after release.

Optional Feature:
FORWARDING_EN
- Defined:
  - Hazard is raised only when an EX-slot match has is_load=1 (load-use), and for WB-slot matches. Stall is 1 cycle.
  - fwd_x_sel_o is registered: computed in ID, updated only on non-stall edges, cleared to 0 on bubble/flush edges. It is valid while the consumer is in EX.
  - fwd_x_sel_o encoding:
    - 2'b01: the producer was in the EX slot (non-load), i.e. the MEM-stage result.
    - 2'b10: the producer was in the MEM slot, i.e. the WB-stage result.
    - 00: none.
  - The EX slot has priority over the MEM slot.
- Undefined: fwd_a_sel_o/fwd_b_sel_o are tied to 0; hazard logic is as above.

Test Plan:
- addi x5 then add x6,x5,x1 back-to-back, no forwarding -> stall_o=1 for 3 cycles, bubble_o=1 on each, stall_cnt_o=3.
- Same sequence with FORWARDING_EN -> no stall; the consumer's fwd_b_sel_o=0, fwd_a_sel_o=01 in EX.
- lw x7 then add x8,x7,x7 with FORWARDING_EN -> 1-cycle stall, then fwd_a_sel_o=fwd_b_sel_o=10.
- Write to x0 followed by a read of x0 -> no stall, no scoreboard entry.
- jump_i during a stall -> flush_if_o=0 until the stall clears, then 1 for one cycle.
- branch_taken_i while a hazard is pending -> stall_o=0, flush_if_o=flush_ex_o=1; next cycle EX/MEM slots are invalid. Assert rst_ni low mid-stall -> all outputs 0 and stall_cnt_o=0 asynchronously.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: RAW hazard detection, stall/bubble generation and flush
// sequencing for the 5-stage core. Tracks in-flight register writes in a
// 3-slot scoreboard (EX, MEM, WB).
// Optional build macro FORWARDING_EN: only load-use (EX slot) and WB-slot
// matches stall; registered operand forward selects are produced for EX.
// Without it, any in-flight producer stalls and the forward selects are 0.
module hazard_ctrl #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  id_valid_i,
  input  logic [ADDR_WIDTH-1:0] id_rs1_addr_i,
  input  logic                  id_rs1_used_i,
  input  logic [ADDR_WIDTH-1:0] id_rs2_addr_i,
  input  logic                  id_rs2_used_i,
  input  logic [ADDR_WIDTH-1:0] id_rd_addr_i,
  input  logic                  id_reg_we_i,
  input  logic                  id_is_load_i,
  input  logic                  jump_i,
  input  logic                  branch_taken_i,
  output logic                  stall_o,
  output logic                  bubble_o,
  output logic                  flush_if_o,
  output logic                  flush_ex_o,
  output logic [1:0]            fwd_a_sel_o,
  output logic [1:0]            fwd_b_sel_o,
  output logic [CNT_WIDTH-1:0]  stall_cnt_o
);

  logic                  ex_vld_q, ex_vld_d;
  logic [ADDR_WIDTH-1:0] ex_rd_q;
  logic                  mem_vld_q, mem_vld_d;
  logic [ADDR_WIDTH-1:0] mem_rd_q;
  logic                  wb_vld_q;
  logic [ADDR_WIDTH-1:0] wb_rd_q;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  hazard;
  logic                  a_ex, a_mem, a_wb, b_ex, b_mem, b_wb;

  // x0 is hardwired, so a source of x0 never matches a producer
  function automatic logic src_hit(input logic vld, input logic [ADDR_WIDTH-1:0] rd,
                                   input logic used, input logic [ADDR_WIDTH-1:0] rs);
    return vld & used & (rs != '0) & (rs == rd);
  endfunction

  assign a_ex  = src_hit(ex_vld_q,  ex_rd_q,  id_rs1_used_i, id_rs1_addr_i);
  assign a_mem = src_hit(mem_vld_q, mem_rd_q, id_rs1_used_i, id_rs1_addr_i);
  assign a_wb  = src_hit(wb_vld_q,  wb_rd_q,  id_rs1_used_i, id_rs1_addr_i);
  assign b_ex  = src_hit(ex_vld_q,  ex_rd_q,  id_rs2_used_i, id_rs2_addr_i);
  assign b_mem = src_hit(mem_vld_q, mem_rd_q, id_rs2_used_i, id_rs2_addr_i);
  assign b_wb  = src_hit(wb_vld_q,  wb_rd_q,  id_rs2_used_i, id_rs2_addr_i);

`ifdef FORWARDING_EN
  logic       ex_ld_q;
  logic [1:0] fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;

  // EX slot is the youngest producer, so it wins over MEM
  function automatic logic [1:0] fwd_sel(input logic hit_ex, input logic hit_mem);
    return hit_ex ? 2'b01 : (hit_mem ? 2'b10 : 2'b00);
  endfunction

  // Regfile is not write-through, so WB producers still stall even with bypass
  assign hazard = id_valid_i & (((a_ex | b_ex) & ex_ld_q) | a_wb | b_wb);

  // Select follows the instruction into EX; a bubble carries no operands
  always_comb begin
    fwd_a_d = 2'b00;
    fwd_b_d = 2'b00;
    if (id_valid_i && !bubble_o) begin
      fwd_a_d = fwd_sel(a_ex, a_mem);
      fwd_b_d = fwd_sel(b_ex, b_mem);
    end
  end

  // Forward selects and EX-slot load flag advance with the ID/EX register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ex_ld_q <= 1'b0;
      fwd_a_q <= 2'b00;
      fwd_b_q <= 2'b00;
    end else begin
      ex_ld_q <= id_is_load_i;
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
    end
  end

  assign fwd_a_sel_o = fwd_a_q;
  assign fwd_b_sel_o = fwd_b_q;
`else
  logic unused_is_load;
  assign unused_is_load = id_is_load_i;

  assign hazard      = id_valid_i & (a_ex | b_ex | a_mem | b_mem | a_wb | b_wb);
  assign fwd_a_sel_o = 2'b00;
  assign fwd_b_sel_o = 2'b00;
`endif

  assign stall_o    = hazard & ~branch_taken_i;
  assign bubble_o   = stall_o | branch_taken_i;
  assign flush_if_o = branch_taken_i | (jump_i & id_valid_i & ~stall_o);
  assign flush_ex_o = branch_taken_i;

  // A taken branch kills both the ID and the EX instructions
  assign ex_vld_d  = id_valid_i & id_reg_we_i & (id_rd_addr_i != '0) & ~stall_o & ~branch_taken_i;
  assign mem_vld_d = ex_vld_q & ~branch_taken_i;
  assign cnt_d     = (stall_o && (cnt_q != '1)) ? cnt_q + 1'b1 : cnt_q;

  // Scoreboard shift: ID -> EX -> MEM -> WB
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ex_vld_q  <= 1'b0;
      ex_rd_q   <= '0;
      mem_vld_q <= 1'b0;
      mem_rd_q  <= '0;
      wb_vld_q  <= 1'b0;
      wb_rd_q   <= '0;
    end else begin
      ex_vld_q  <= ex_vld_d;
      ex_rd_q   <= id_rd_addr_i;
      mem_vld_q <= mem_vld_d;
      mem_rd_q  <= ex_rd_q;
      wb_vld_q  <= mem_vld_q;
      wb_rd_q   <= mem_rd_q;
    end
  end

  // Saturating stall-cycle performance counter
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign stall_cnt_o = cnt_q;

endmodule
